// File: rtl/pipe_ctrl_pkg.sv
// Shared encodings for the RV32 pipeline sequencer: FSM states, opcode and
// register constants, and the per-stage control bundles it can emit.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        LU_STALL = 2'd1,
        MEM_WAIT = 2'd2
    } state_e;

    localparam logic [6:0] OPC_LOAD = 7'b0000011;
    localparam logic [4:0] REG_ZERO = 5'd0;

    typedef struct packed {
        logic en_if;
        logic en_de;
        logic en_exe;
        logic en_acc;
        logic en_wb;
        logic flush_if;
        logic flush_de;
        logic bubble_exe;
        logic bubble_wb;
    } ctrl_t;

    // Field order: en_if en_de en_exe en_acc en_wb | flush_if flush_de bubble_exe bubble_wb
    localparam ctrl_t CTRL_RESET    = 9'b00000_1111;
    localparam ctrl_t CTRL_RUN      = 9'b11111_0000;
    localparam ctrl_t CTRL_LU       = 9'b00111_0010;
    localparam ctrl_t CTRL_MEM      = 9'b00001_0001;
    localparam ctrl_t CTRL_REDIRECT = 9'b11111_1100;

endpackage

// File: rtl/pipe_ctrl_if.sv
// Pipeline-side hazard inputs and per-stage control outputs of pipe_ctrl.
// The pipeline datapath is the master; the sequencer is the slave.
interface pipe_ctrl_if #(
    parameter int CNT_W = 32
);
    logic [4:0]       de_rs1;
    logic [4:0]       de_rs2;
    logic             de_use_rs1;
    logic             de_use_rs2;
    logic             exe_valid;
    logic [4:0]       exe_rd;
    logic             exe_is_load;
    logic             redirect_exe;
    logic             dmem_req_acc;
    logic             dmem_ready;

    logic             en_if;
    logic             en_de;
    logic             en_exe;
    logic             en_acc;
    logic             en_wb;
    logic             flush_if;
    logic             flush_de;
    logic             bubble_exe;
    logic             bubble_wb;
    logic             mem_err;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    modport master (
        output de_rs1, de_rs2, de_use_rs1, de_use_rs2,
        output exe_valid, exe_rd, exe_is_load, redirect_exe,
        output dmem_req_acc, dmem_ready,
        input  en_if, en_de, en_exe, en_acc, en_wb,
        input  flush_if, flush_de, bubble_exe, bubble_wb,
        input  mem_err, stall_cnt, flush_cnt
    );

    modport slave (
        input  de_rs1, de_rs2, de_use_rs1, de_use_rs2,
        input  exe_valid, exe_rd, exe_is_load, redirect_exe,
        input  dmem_req_acc, dmem_ready,
        output en_if, en_de, en_exe, en_acc, en_wb,
        output flush_if, flush_de, bubble_exe, bubble_wb,
        output mem_err, stall_cnt, flush_cnt
    );

endinterface

// File: rtl/pipe_ctrl_lu_detect.sv
// Load-use hazard detector: a real load in EXE writing a register that the
// DE instruction reads. Writes to x0 never create a dependency.
module pipe_ctrl_lu_detect
    import pipe_ctrl_pkg::*;
(
    input  logic [4:0] de_rs1_i,
    input  logic [4:0] de_rs2_i,
    input  logic       de_use_rs1_i,
    input  logic       de_use_rs2_i,
    input  logic       exe_valid_i,
    input  logic [4:0] exe_rd_i,
    input  logic       exe_is_load_i,
    output logic       hazard_o
);

    logic load_writes;
    logic rs1_hit;
    logic rs2_hit;

    assign load_writes = exe_valid_i && exe_is_load_i && (exe_rd_i != REG_ZERO);
    assign rs1_hit     = de_use_rs1_i && (de_rs1_i == exe_rd_i);
    assign rs2_hit     = de_use_rs2_i && (de_rs2_i == exe_rd_i);
    assign hazard_o    = load_writes && (rs1_hit || rs2_hit);

endmodule

// File: rtl/pipe_ctrl.sv
// Five-stage pipeline sequencer: stage enables and bubble/flush controls for
// load-use, EXE redirects and dmem wait states, plus watchdog and counters.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int LOAD_USE_CYCLES = 1,
    parameter int MEM_TIMEOUT     = 255,
    parameter int CNT_W           = 32
) (
    input  logic     clk,
    input  logic     rst,
    pipe_ctrl_if.slave bus
);

    localparam logic [15:0] TIMEOUT   = 16'(MEM_TIMEOUT);
    localparam logic [1:0]  LU_RELOAD = 2'(LOAD_USE_CYCLES - 1);

    state_e           state_q, state_d;
    logic [1:0]       lu_cnt_q, lu_cnt_d;
    logic [15:0]      wait_cnt_q, wait_cnt_d;
    logic             mem_err_q, mem_err_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    ctrl_t ctrl;
    logic  hazard;
    logic  mem_wait_req;
    logic  mem_stall;
    logic  mem_timeout;
    logic  redirect;
    logic  in_lu;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    pipe_ctrl_lu_detect u_lu_detect (
        .de_rs1_i      (bus.de_rs1),
        .de_rs2_i      (bus.de_rs2),
        .de_use_rs1_i  (bus.de_use_rs1),
        .de_use_rs2_i  (bus.de_use_rs2),
        .exe_valid_i   (bus.exe_valid),
        .exe_rd_i      (bus.exe_rd),
        .exe_is_load_i (bus.exe_is_load),
        .hazard_o      (hazard)
    );

    // wait_cnt never exceeds TIMEOUT: the timeout cycle advances and clears it.
    assign mem_wait_req = bus.dmem_req_acc && !bus.dmem_ready;
    assign mem_stall    = mem_wait_req && (wait_cnt_q < TIMEOUT);
    assign mem_timeout  = mem_wait_req && (wait_cnt_q == TIMEOUT);
    assign redirect     = bus.redirect_exe && bus.exe_valid;
    // A LU_STALL interrupted by a dmem wait resumes from the saved lu_cnt.
    assign in_lu        = (state_q != RUN) && (lu_cnt_q != 2'd0);

    always_comb begin
        ctrl        = CTRL_RUN;
        state_d     = state_q;
        lu_cnt_d    = lu_cnt_q;
        wait_cnt_d  = 16'd0;
        mem_err_d   = mem_err_q || mem_timeout;
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;

        if (rst) begin
            ctrl = CTRL_RESET;
        end else if (mem_stall) begin
            ctrl       = CTRL_MEM;
            wait_cnt_d = wait_cnt_q + 16'd1;
            state_d    = MEM_WAIT;
        end else if (redirect) begin
            // The DE instruction is wrong-path, so any load-use there is moot.
            ctrl        = CTRL_REDIRECT;
            lu_cnt_d    = 2'd0;
            state_d     = RUN;
            flush_cnt_d = sat_inc(flush_cnt_q);
        end else if (in_lu) begin
            ctrl     = CTRL_LU;
            lu_cnt_d = lu_cnt_q - 2'd1;
            state_d  = (lu_cnt_q == 2'd1) ? RUN : LU_STALL;
        end else if (hazard) begin
            ctrl    = CTRL_LU;
            state_d = RUN;
            if (LOAD_USE_CYCLES > 1) begin
                lu_cnt_d = LU_RELOAD;
                state_d  = LU_STALL;
            end
        end else begin
            state_d = RUN;
        end

        if (!ctrl.en_de) begin
            stall_cnt_d = sat_inc(stall_cnt_q);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= RUN;
            lu_cnt_q    <= 2'd0;
            wait_cnt_q  <= 16'd0;
            mem_err_q   <= 1'b0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            lu_cnt_q    <= lu_cnt_d;
            wait_cnt_q  <= wait_cnt_d;
            mem_err_q   <= mem_err_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign bus.en_if      = ctrl.en_if;
    assign bus.en_de      = ctrl.en_de;
    assign bus.en_exe     = ctrl.en_exe;
    assign bus.en_acc     = ctrl.en_acc;
    assign bus.en_wb      = ctrl.en_wb;
    assign bus.flush_if   = ctrl.flush_if;
    assign bus.flush_de   = ctrl.flush_de;
    assign bus.bubble_exe = ctrl.bubble_exe;
    assign bus.bubble_wb  = ctrl.bubble_wb;
    assign bus.mem_err    = mem_err_q;
    assign bus.stall_cnt  = stall_cnt_q;
    assign bus.flush_cnt  = flush_cnt_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: a vector table of single-cycle control
// decisions plus hand sequences for stalls, watchdog, reset and saturation.
module tb_pipe_ctrl;

    localparam logic [8:0] E_RST = 9'b00000_1111;
    localparam logic [8:0] E_RUN = 9'b11111_0000;
    localparam logic [8:0] E_LU  = 9'b00111_0010;
    localparam logic [8:0] E_MEM = 9'b00001_0001;
    localparam logic [8:0] E_RED = 9'b11111_1100;

    typedef struct {
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       u1;
        logic       u2;
        logic       ev;
        logic [4:0] rd;
        logic       ld;
        logic       redir;
        logic       req;
        logic       rdy;
        logic [8:0] exp;
    } vec_t;

    logic       clk;
    logic       rst;
    logic [4:0] rs1, rs2, rd;
    logic       u1, u2, ev, ld, redir, req, rdy;
    int         checks;
    int         failures;
    vec_t       tbl[15];

    pipe_ctrl_if #(.CNT_W(32)) ifa ();
    pipe_ctrl_if #(.CNT_W(4))  ifb ();

    pipe_ctrl #(.LOAD_USE_CYCLES(1), .MEM_TIMEOUT(8), .CNT_W(32)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (ifa)
    );

    pipe_ctrl #(.LOAD_USE_CYCLES(3), .MEM_TIMEOUT(8), .CNT_W(4)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (ifb)
    );

    assign ifa.de_rs1 = rs1;        assign ifb.de_rs1 = rs1;
    assign ifa.de_rs2 = rs2;        assign ifb.de_rs2 = rs2;
    assign ifa.de_use_rs1 = u1;     assign ifb.de_use_rs1 = u1;
    assign ifa.de_use_rs2 = u2;     assign ifb.de_use_rs2 = u2;
    assign ifa.exe_valid = ev;      assign ifb.exe_valid = ev;
    assign ifa.exe_rd = rd;         assign ifb.exe_rd = rd;
    assign ifa.exe_is_load = ld;    assign ifb.exe_is_load = ld;
    assign ifa.redirect_exe = redir; assign ifb.redirect_exe = redir;
    assign ifa.dmem_req_acc = req;  assign ifb.dmem_req_acc = req;
    assign ifa.dmem_ready = rdy;    assign ifb.dmem_ready = rdy;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    function automatic logic [8:0] ctrl_a();
        return {ifa.en_if, ifa.en_de, ifa.en_exe, ifa.en_acc, ifa.en_wb,
                ifa.flush_if, ifa.flush_de, ifa.bubble_exe, ifa.bubble_wb};
    endfunction

    function automatic logic [8:0] ctrl_b();
        return {ifb.en_if, ifb.en_de, ifb.en_exe, ifb.en_acc, ifb.en_wb,
                ifb.flush_if, ifb.flush_de, ifb.bubble_exe, ifb.bubble_wb};
    endfunction

    function automatic vec_t mk(input logic [4:0] r1, input logic [4:0] r2,
                                input logic a1, input logic a2, input logic v,
                                input logic [4:0] d, input logic l, input logic rx,
                                input logic rq, input logic ry, input logic [8:0] e);
        vec_t t;
        t.rs1 = r1; t.rs2 = r2; t.u1 = a1; t.u2 = a2; t.ev = v; t.rd = d;
        t.ld = l; t.redir = rx; t.req = rq; t.rdy = ry; t.exp = e;
        return t;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rs1 = 5'd0; rs2 = 5'd0; rd = 5'd0;
        u1 = 1'b0; u2 = 1'b0; ev = 1'b0; ld = 1'b0;
        redir = 1'b0; req = 1'b0; rdy = 1'b0;
    endtask

    task automatic set_hazard();
        idle();
        rs1 = 5'd5; u1 = 1'b1; rd = 5'd5; ev = 1'b1; ld = 1'b1;
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    initial begin
        checks = 0;
        failures = 0;
        idle();
        rst = 1'b1;
        #2;
        chk("reset_ctrl_a", 32'(ctrl_a()), 32'(E_RST));
        chk("reset_stall_a", ifa.stall_cnt, 32'd0);
        chk("reset_flush_a", ifa.flush_cnt, 32'd0);
        chk("reset_memerr_a", 32'(ifa.mem_err), 32'd0);
        step();
        step();
        rst = 1'b0;

        // rs1 rs2 u1 u2 ev rd ld redir req rdy exp
        tbl[0]  = mk(5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 0, 0, 0, E_RUN);
        tbl[1]  = mk(5'd5, 5'd0, 1, 0, 1, 5'd5, 1, 0, 0, 0, E_LU);
        tbl[2]  = mk(5'd1, 5'd7, 0, 1, 1, 5'd7, 1, 0, 0, 0, E_LU);
        tbl[3]  = mk(5'd0, 5'd0, 1, 1, 1, 5'd0, 1, 0, 0, 0, E_RUN);
        tbl[4]  = mk(5'd5, 5'd0, 0, 0, 1, 5'd5, 1, 0, 0, 0, E_RUN);
        tbl[5]  = mk(5'd5, 5'd0, 1, 0, 1, 5'd5, 0, 0, 0, 0, E_RUN);
        tbl[6]  = mk(5'd5, 5'd0, 1, 0, 0, 5'd5, 1, 0, 0, 0, E_RUN);
        tbl[7]  = mk(5'd3, 5'd9, 1, 0, 1, 5'd9, 1, 0, 0, 0, E_RUN);
        tbl[8]  = mk(5'd0, 5'd0, 0, 0, 1, 5'd0, 0, 1, 0, 0, E_RED);
        tbl[9]  = mk(5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 1, 0, 0, E_RUN);
        tbl[10] = mk(5'd5, 5'd0, 1, 0, 1, 5'd5, 1, 1, 0, 0, E_RED);
        tbl[11] = mk(5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 0, 1, 0, E_MEM);
        tbl[12] = mk(5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 0, 1, 1, E_RUN);
        tbl[13] = mk(5'd5, 5'd0, 1, 0, 1, 5'd5, 1, 1, 1, 0, E_MEM);
        tbl[14] = mk(5'd5, 5'd0, 1, 0, 1, 5'd5, 1, 0, 1, 1, E_LU);

        for (int i = 0; i < 15; i++) begin
            rs1 = tbl[i].rs1; rs2 = tbl[i].rs2; u1 = tbl[i].u1; u2 = tbl[i].u2;
            ev = tbl[i].ev; rd = tbl[i].rd; ld = tbl[i].ld; redir = tbl[i].redir;
            req = tbl[i].req; rdy = tbl[i].rdy;
            #1;
            chk($sformatf("vec%0d", i), 32'(ctrl_a()), 32'(tbl[i].exp));
            step();
        end

        // Single-cycle load-use bubble
        do_reset();
        set_hazard();
        #1;
        chk("lu1_detect", 32'(ctrl_a()), 32'(E_LU));
        step();
        idle();
        #1;
        chk("lu1_release", 32'(ctrl_a()), 32'(E_RUN));
        chk("lu1_stall_cnt", ifa.stall_cnt, 32'd1);

        // No hazard through x0 or an unused rs1
        do_reset();
        set_hazard();
        rd = 5'd0; rs1 = 5'd0;
        #1;
        chk("nohaz_x0", 32'(ctrl_a()), 32'(E_RUN));
        step();
        set_hazard();
        u1 = 1'b0;
        #1;
        chk("nohaz_unused", 32'(ctrl_a()), 32'(E_RUN));
        step();
        chk("nohaz_stall_cnt", ifa.stall_cnt, 32'd0);

        // Redirect beats load-use
        do_reset();
        set_hazard();
        redir = 1'b1;
        #1;
        chk("redir_ctrl", 32'(ctrl_a()), 32'(E_RED));
        step();
        idle();
        #1;
        chk("redir_flush_cnt", ifa.flush_cnt, 32'd1);
        chk("redir_stall_cnt", ifa.stall_cnt, 32'd0);

        // Four dmem wait cycles then ready
        do_reset();
        req = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk($sformatf("memw_frozen%0d", i), 32'(ctrl_a()), 32'(E_MEM));
            step();
        end
        rdy = 1'b1;
        #1;
        chk("memw_advance", 32'(ctrl_a()), 32'(E_RUN));
        chk("memw_stall_cnt", ifa.stall_cnt, 32'd4);
        step();
        idle();
        #1;
        chk("memw_stall_after", ifa.stall_cnt, 32'd4);
        chk("memw_no_err", 32'(ifa.mem_err), 32'd0);

        // Watchdog: 8 frozen cycles, 9th advances and raises mem_err
        do_reset();
        req = 1'b1;
        for (int i = 0; i < 8; i++) begin
            #1;
            chk($sformatf("wd_frozen%0d", i), 32'(ctrl_a()), 32'(E_MEM));
            step();
        end
        #1;
        chk("wd_advance", 32'(ctrl_a()), 32'(E_RUN));
        chk("wd_err_before", 32'(ifa.mem_err), 32'd0);
        step();
        idle();
        #1;
        chk("wd_err_set", 32'(ifa.mem_err), 32'd1);
        chk("wd_stall_cnt", ifa.stall_cnt, 32'd8);
        step();
        step();
        chk("wd_err_sticky", 32'(ifa.mem_err), 32'd1);
        do_reset();
        chk("wd_err_cleared", 32'(ifa.mem_err), 32'd0);

        // Three-bubble load-use interrupted by a dmem wait on the 2nd bubble
        do_reset();
        set_hazard();
        #1;
        chk("lu3_b1", 32'(ctrl_b()), 32'(E_LU));
        step();
        idle();
        req = 1'b1;
        #1;
        chk("lu3_mem0", 32'(ctrl_b()), 32'(E_MEM));
        step();
        #1;
        chk("lu3_mem1", 32'(ctrl_b()), 32'(E_MEM));
        step();
        rdy = 1'b1;
        #1;
        chk("lu3_b2", 32'(ctrl_b()), 32'(E_LU));
        step();
        idle();
        #1;
        chk("lu3_b3", 32'(ctrl_b()), 32'(E_LU));
        step();
        #1;
        chk("lu3_done", 32'(ctrl_b()), 32'(E_RUN));
        chk("lu3_stall_cnt", 32'(ifb.stall_cnt), 32'd5);

        // Reset in the middle of MEM_WAIT with bubbles still pending
        set_hazard();
        step();
        idle();
        req = 1'b1;
        step();
        rst = 1'b1;
        #1;
        chk("rstmid_ctrl", 32'(ctrl_b()), 32'(E_RST));
        chk("rstmid_stall", 32'(ifb.stall_cnt), 32'd0);
        chk("rstmid_flush", 32'(ifb.flush_cnt), 32'd0);
        idle();
        #2;
        rst = 1'b0;
        #1;
        chk("rstmid_run0", 32'(ctrl_b()), 32'(E_RUN));
        step();
        #1;
        chk("rstmid_run1", 32'(ctrl_b()), 32'(E_RUN));

        // Counter saturation on the 4-bit instance
        do_reset();
        req = 1'b1;
        for (int i = 0; i < 20; i++) step();
        idle();
        #1;
        chk("sat_stall", 32'(ifb.stall_cnt), 32'd15);
        chk("sat_memerr_b", 32'(ifb.mem_err), 32'd1);
        ev = 1'b1;
        redir = 1'b1;
        for (int i = 0; i < 17; i++) step();
        idle();
        #1;
        chk("sat_flush", 32'(ifb.flush_cnt), 32'd15);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
